// File: rtl/bundle_majority_kernel.sv
// Per-bit majority-vote bundler for binary hypervector words.
// Each bundle runs IDLE -> ACCUM -> RESOLVE -> DONE. Per-bit vote counters
// accumulate operand bits, then RESOLVE registers the majority result.
module bundle_majority_kernel #(
  parameter int                     HV_DATA_WIDTH = 32,
  parameter int                     COUNT_WIDTH   = 6,
  parameter logic [HV_DATA_WIDTH-1:0] TIE_PATTERN = 32'hAAAAAAAA
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid,
  input  logic                     first,
  input  logic                     last,
  input  logic [HV_DATA_WIDTH-1:0] data_in,
  output logic [HV_DATA_WIDTH-1:0] data_out,
  output logic                     ready,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                                    state_q, state_d;
  logic [HV_DATA_WIDTH-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]                    n_q, n_d;
  logic [HV_DATA_WIDTH-1:0]                  data_out_q, data_out_d;
  logic                                      xfer;

  // Increment that sticks at the counter ceiling instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                     input logic inc);
    if (inc && (v != CNT_MAX)) return v + COUNT_WIDTH'(1);
    return v;
  endfunction

  // Majority decision for one bit; the extra bit keeps 2*cnt exact.
  function automatic logic vote(input logic [COUNT_WIDTH-1:0] cnt,
                                input logic [COUNT_WIDTH-1:0] n,
                                input logic                   tie);
    logic [COUNT_WIDTH:0] twice;
    logic [COUNT_WIDTH:0] total;
    twice = {cnt, 1'b0};
    total = {1'b0, n};
    if (twice > total) return 1'b1;
    if (twice == total) return tie;
    return 1'b0;
  endfunction

  assign ready    = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign done     = (state_q == S_DONE);
  assign data_out = data_out_q;
  assign xfer     = valid && ready;

  // Next-state, counter update and result resolution.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    data_out_d = data_out_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer && first) begin
          for (int i = 0; i < HV_DATA_WIDTH; i++) cnt_d[i] = COUNT_WIDTH'(data_in[i]);
          n_d     = COUNT_WIDTH'(1);
          state_d = last ? S_RESOLVE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (xfer) begin
          if (first) begin
            for (int i = 0; i < HV_DATA_WIDTH; i++) cnt_d[i] = COUNT_WIDTH'(data_in[i]);
            n_d = COUNT_WIDTH'(1);
          end else if (n_q != CNT_MAX) begin
            // Once n is saturated the whole bundle freezes; cnt can never pass n.
            for (int i = 0; i < HV_DATA_WIDTH; i++) cnt_d[i] = sat_inc(cnt_q[i], data_in[i]);
            n_d = sat_inc(n_q, 1'b1);
          end
          if (last) state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        for (int i = 0; i < HV_DATA_WIDTH; i++) data_out_d[i] = vote(cnt_q[i], n_q, TIE_PATTERN[i]);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and result register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      data_out_q <= data_out_d;
    end
  end

endmodule
